// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the RV32-subset multi-cycle controller.
//   - Opcode values of the four supported instruction classes
//   - ALU operation select encodings
//   - Controller state encoding (3 bits; value 7 is never entered)
package rv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    return op inside {OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   master : controller side (takes opcode/zero/mem_ready, drives controls,
//            error, state and the retired-instruction count)
//   slave  : datapath/memory side
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             error;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
           alu_src, alu_op, reg_write, mem_to_reg, error, state, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
           alu_src, alu_op, reg_write, mem_to_reg, error, state, retired
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait watchdog.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (controller is entering a memory phase)
//   waiting    : controller is in a phase that waits on memory
//   ready      : memory handshake for this cycle
//   timeout    : this is the MEM_TIMEOUT-th consecutive cycle without ready
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  input  logic ready,
  output logic timeout
);
  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (waiting && !ready && wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Fires on the cycle whose miss would take the count to MEM_TIMEOUT, so the
  // controller leaves after exactly MEM_TIMEOUT unanswered cycles; a ready on
  // that cycle suppresses it.
  assign timeout = waiting && !ready && (wait_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for an RV32 subset (R-type, load, store, branch).
//   clk, reset : clock, synchronous active-high reset
//   bus        : multicycle_ctrl_if.master - opcode/zero/mem_ready in;
//                datapath controls, error, state, retired count out
// Controls are decoded from the registered state; only mem_ready and zero
// act combinationally.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);
  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             timeout;
  logic             waiting;
  logic             clear;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  assign clear   = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .waiting (waiting),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_op     = ALUOP_ADD;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end

      S_DECODE: state_d = is_legal_op(bus.opcode) ? S_EXEC : S_ERR;

      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            bus.alu_op = ALUOP_FUNCT;
            state_d    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            bus.alu_src = 1'b1;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            bus.alu_op = ALUOP_SUB;
            if (bus.zero) begin
              bus.pc_write = 1'b1;
              bus.pc_src   = 1'b1;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_ERR;
        endcase
      end

      S_MEM: begin
        bus.i_or_d    = 1'b1;
        bus.mem_read  = (op_q == OP_LOAD);
        bus.mem_write = (op_q == OP_STORE);
        if (bus.mem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end

      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (op_q == OP_LOAD);
        retire         = 1'b1;
        state_d        = S_FETCH;
      end

      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.error   = (state_q == S_ERR);
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed per-cycle expectations.
module tb_multicycle_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_ERR = 3'd6;

  localparam logic [6:0] RTYPE = 7'b0110011, LOAD = 7'b0000011, STORE = 7'b0100011,
                         BRANCH = 7'b1100011, ILLEGAL = 7'b0010011;

  // ctrl = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
  //         alu_src, alu_op[1:0], reg_write, mem_to_reg}
  localparam logic [10:0] C_NONE   = 11'h000;
  localparam logic [10:0] F_WAIT   = 11'h080;
  localparam logic [10:0] F_GO     = 11'h580;
  localparam logic [10:0] EX_R     = 11'h008;
  localparam logic [10:0] EX_LS    = 11'h010;
  localparam logic [10:0] EX_BR_T  = 11'h604;
  localparam logic [10:0] EX_BR_N  = 11'h004;
  localparam logic [10:0] MEM_LD   = 11'h0A0;
  localparam logic [10:0] MEM_ST   = 11'h060;
  localparam logic [10:0] WB_R     = 11'h002;
  localparam logic [10:0] WB_LD    = 11'h003;

  logic clk;
  logic reset;
  logic [10:0] ctrl;
  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign ctrl = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
                 bus.i_or_d, bus.alu_src, bus.alu_op, bus.reg_write, bus.mem_to_reg};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply this cycle's inputs, check state and controls, advance one clock.
  task automatic cyc(input string tag, input logic rdy, input logic z,
                     input logic [2:0] st, input logic [10:0] ct);
    bus.mem_ready = rdy;
    bus.zero      = z;
    #1;
    check({tag, "/state"}, 64'(bus.state), 64'(st));
    check({tag, "/ctrl"}, 64'(ctrl), 64'(ct));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst/state", 64'(bus.state), 64'(ST_IDLE));
    check("rst/ctrl", 64'(ctrl), 64'(C_NONE));
    check("rst/retired", 64'(bus.retired), 64'd0);
    check("rst/error", 64'(bus.error), 64'd0);

    // R-type, mem_ready=1
    bus.opcode = RTYPE;
    cyc("r/idle", 1'b0, 1'b0, ST_IDLE, C_NONE);
    cyc("r/fetch", 1'b1, 1'b0, ST_FETCH, F_GO);
    cyc("r/dec", 1'b1, 1'b0, ST_DECODE, C_NONE);
    cyc("r/exec", 1'b1, 1'b0, ST_EXEC, EX_R);
    check("r/ret_before_wb", 64'(bus.retired), 64'd0);
    cyc("r/wb", 1'b1, 1'b0, ST_WB, WB_R);
    check("r/retired", 64'(bus.retired), 64'd1);

    // Load: 3 FETCH stalls, 2 MEM stalls -> 10 cycles
    bus.opcode = LOAD;
    for (int i = 0; i < 3; i++) cyc("ld/fetch_wait", 1'b0, 1'b0, ST_FETCH, F_WAIT);
    cyc("ld/fetch", 1'b1, 1'b0, ST_FETCH, F_GO);
    cyc("ld/dec", 1'b0, 1'b0, ST_DECODE, C_NONE);
    cyc("ld/exec", 1'b0, 1'b0, ST_EXEC, EX_LS);
    for (int i = 0; i < 2; i++) cyc("ld/mem_wait", 1'b0, 1'b0, ST_MEM, MEM_LD);
    cyc("ld/mem", 1'b1, 1'b0, ST_MEM, MEM_LD);
    cyc("ld/wb", 1'b1, 1'b0, ST_WB, WB_LD);
    check("ld/retired", 64'(bus.retired), 64'd2);

    // Branch taken then not taken
    bus.opcode = BRANCH;
    cyc("bt/fetch", 1'b1, 1'b0, ST_FETCH, F_GO);
    cyc("bt/dec", 1'b1, 1'b0, ST_DECODE, C_NONE);
    cyc("bt/exec", 1'b1, 1'b1, ST_EXEC, EX_BR_T);
    cyc("bn/fetch", 1'b1, 1'b0, ST_FETCH, F_GO);
    cyc("bn/dec", 1'b1, 1'b0, ST_DECODE, C_NONE);
    cyc("bn/exec", 1'b1, 1'b0, ST_EXEC, EX_BR_N);
    check("br/retired", 64'(bus.retired), 64'd4);

    // Store then illegal opcode
    bus.opcode = STORE;
    cyc("st/fetch", 1'b1, 1'b0, ST_FETCH, F_GO);
    cyc("st/dec", 1'b1, 1'b0, ST_DECODE, C_NONE);
    cyc("st/exec", 1'b1, 1'b0, ST_EXEC, EX_LS);
    cyc("st/mem", 1'b1, 1'b0, ST_MEM, MEM_ST);
    check("st/retired", 64'(bus.retired), 64'd5);
    bus.opcode = ILLEGAL;
    cyc("ill/fetch", 1'b1, 1'b0, ST_FETCH, F_GO);
    cyc("ill/dec", 1'b1, 1'b0, ST_DECODE, C_NONE);
    for (int i = 0; i < 20; i++) begin
      check("ill/error", 64'(bus.error), 64'd1);
      cyc("ill/err", 1'b1, 1'b1, ST_ERR, C_NONE);
    end
    check("ill/retired", 64'(bus.retired), 64'd5);

    // FETCH timeout: 16 unanswered cycles -> ERR
    do_reset();
    check("to/rst_error", 64'(bus.error), 64'd0);
    cyc("to/idle", 1'b0, 1'b0, ST_IDLE, C_NONE);
    for (int i = 0; i < 16; i++) cyc("to/fetch_wait", 1'b0, 1'b0, ST_FETCH, F_WAIT);
    check("to/state", 64'(bus.state), 64'(ST_ERR));
    check("to/error", 64'(bus.error), 64'd1);

    // Ready on the boundary cycle wins over the timeout
    do_reset();
    cyc("tb/idle", 1'b0, 1'b0, ST_IDLE, C_NONE);
    for (int i = 0; i < 15; i++) cyc("tb/fetch_wait", 1'b0, 1'b0, ST_FETCH, F_WAIT);
    bus.opcode = STORE;
    cyc("tb/fetch_edge", 1'b1, 1'b0, ST_FETCH, F_GO);
    check("tb/state", 64'(bus.state), 64'(ST_DECODE));
    check("tb/error", 64'(bus.error), 64'd0);

    // Complete one store, then reset in the middle of the next store's MEM
    cyc("rs/dec", 1'b1, 1'b0, ST_DECODE, C_NONE);
    cyc("rs/exec", 1'b1, 1'b0, ST_EXEC, EX_LS);
    cyc("rs/mem", 1'b1, 1'b0, ST_MEM, MEM_ST);
    check("rs/retired1", 64'(bus.retired), 64'd1);
    cyc("rs/fetch", 1'b1, 1'b0, ST_FETCH, F_GO);
    cyc("rs/dec2", 1'b1, 1'b0, ST_DECODE, C_NONE);
    cyc("rs/exec2", 1'b1, 1'b0, ST_EXEC, EX_LS);
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rs/mem_state", 64'(bus.state), 64'(ST_MEM));
    check("rs/mem_ctrl", 64'(ctrl), 64'(MEM_ST));
    tick();
    reset = 1'b0;
    check("rs/state", 64'(bus.state), 64'(ST_IDLE));
    check("rs/mem_write", 64'(bus.mem_write), 64'd0);
    check("rs/retired", 64'(bus.retired), 64'd0);
    check("rs/error", 64'(bus.error), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32 subset datapath: R-type (0110011), load (0000011), store (0100011) and branch (1100011).
- Steps the shared ALU, register file and the single memory port through FETCH/DECODE/EXEC/MEM/WB, one phase per cycle.
- Stalls on a memory ready handshake.
- Counts retired instructions.
- Traps on illegal opcodes and on memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory access may wait for mem_ready before the block enters ERR.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  7  instruction[6:0] from the instruction register, valid from DECODE onward
zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory has completed the current read/write this cycle
pc_write  out  1  load PC this cycle
pc_src  out  1  0 = PC+4, 1 = branch target
ir_write  out  1  load instruction register
mem_read  out  1  memory read request (fetch or load)
mem_write  out  1  memory write request (store)
i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result
alu_src  out  1  ALU B operand: 0 = rs2, 1 = immediate
alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback select: 0 = ALU, 1 = memory data
error  out  1  sticky: block is in ERR
state  out  3  current state encoding, for debug
retired  out  CNT_W  instructions completed since reset

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6. Encoding 7 is unreachable and goes to ERR.
- Reset (synchronous, wins over every other event, including mid-access):
  - state=IDLE, op_q=0, wait_cnt=0, retired=0.
  - All control outputs are 0 in IDLE.
- Control outputs are a decode of the registered state. The only Mealy terms are those that use mem_ready or zero.
- IDLE -> FETCH unconditionally on the next cycle.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0, and go to DECODE. Otherwise stay.
- DECODE:
  - Latch op_q<=opcode. Control outputs are 0.
  - Next state is EXEC when opcode is one of the four legal values, else ERR.
- EXEC (decoded from op_q):
  - R-type: alu_src=0, alu_op=10, next WB.
  - Load/store: alu_src=1, alu_op=00, next MEM.
  - Branch: alu_src=0, alu_op=01. When zero=1, pc_write=1 and pc_src=1. Next FETCH; the branch retires.
- MEM: i_or_d=1; load drives mem_read=1, store drives mem_write=1. Waits for mem_ready:
  - Load with mem_ready -> WB.
  - Store with mem_ready -> FETCH; the store retires.
- WB:
  - reg_write=1 for one cycle; mem_to_reg=1 for load, 0 for R-type.
  - Next FETCH; the instruction retires.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM and increments each cycle in FETCH or MEM while mem_ready=0.
  - When wait_cnt reaches MEM_TIMEOUT with mem_ready still 0, the block enters ERR.
  - mem_ready arriving on that same cycle completes the access normally; it has priority over the timeout.
- ERR: all control outputs 0, error=1. Held until reset.
- Retirement: retired increments by 1 on the last cycle of each instruction (WB, branch EXEC, store MEM with mem_ready). It wraps modulo 2^CNT_W with no saturation.
- Latency with mem_ready tied to 1:
  - R-type: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch: 3 cycles, taken or not
- At most one pc_write per instruction, except a taken branch: PC+4 is written in FETCH and the target in EXEC.

Decomposition:
- Shared package rv_ctrl_pkg:
  - Opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - ALU op constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - State encodings S_IDLE..S_ERR.
- Sub-module mem_wait_timer holds wait_cnt and its timeout compare. Its ports are clk, reset, clear, waiting, ready, and timeout.
- The FSM and output decode stay in multicycle_ctrl.

Test Plan:
- Reset, then an R-type with mem_ready=1 -> state 0,1,2,3,5,1. reg_write=1 only in WB with mem_to_reg=0. retired=1 after WB.
- Load with mem_ready low for 3 FETCH cycles and 2 MEM cycles:
  - FETCH holds mem_read=1 for 4 cycles; ir_write pulses once.
  - MEM holds mem_read=1, i_or_d=1 for 3 cycles.
  - WB has mem_to_reg=1. Total latency is 10 cycles.
- Branch with zero=1, then a branch with zero=0:
  - First: EXEC shows alu_op=01, pc_write=1, pc_src=1.
  - Second: EXEC has pc_write=0.
  - Both take 3 cycles; retired advances by 2.
- Store, then opcode 0010011 -> store drives mem_write=1 in MEM with no reg_write. The illegal opcode then goes DECODE->ERR with error=1, and ERR is held for 20 cycles.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> ERR after 16 wait cycles. In a second run, mem_ready=1 on exactly that cycle goes to DECODE instead.
- Reset asserted in the middle of MEM of a store -> next cycle state=IDLE, mem_write=0, retired=0, error=0.
